// File: rtl/ddr2_64bit_local_req_frontend.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_64bit_local_req_frontend
// Description : Client command/write-beat front end for the DDR2 controller
//               local port. It returns read data with a per-burst last marker.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr2_64bit_local_req_frontend #(
    parameter int ADDR_W          = 26,
    parameter int DATA_W          = 128,
    parameter int BE_W            = 16,
    parameter int SIZE_W          = 6,
    parameter int MAX_BURST       = 32,
    parameter int MAX_OUTSTANDING = 64,
    parameter int RD_CMD_DEPTH    = 4
) (
    input  logic              phy_clk,
    input  logic              reset_phy_clk,
    input  logic              local_init_done,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [SIZE_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    output logic [ADDR_W-1:0] local_address,
    output logic [SIZE_W-1:0] local_size,
    output logic              local_burstbegin,
    output logic              local_read_req,
    output logic              local_write_req,
    output logic [DATA_W-1:0] local_wdata,
    output logic [BE_W-1:0]   local_be,
    input  logic              local_ready,
    input  logic [DATA_W-1:0] local_rdata,
    input  logic              local_rdata_valid,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic [6:0]        outstanding_beats,
    output logic              rd_underflow
);

    // RD_CMD_DEPTH must be a power of two and at least 2.
    localparam int                C_PTR_W     = $clog2(RD_CMD_DEPTH);
    localparam logic [C_PTR_W:0]  C_FIFO_FULL = (C_PTR_W+1)'(RD_CMD_DEPTH);
    localparam logic [C_PTR_W-1:0] C_PTR_ONE  = C_PTR_W'(1);
    localparam logic [7:0]        C_MAX_OUT   = 8'(MAX_OUTSTANDING);
    localparam logic [SIZE_W-1:0] C_MAX_BURST = SIZE_W'(MAX_BURST);
    localparam logic [SIZE_W-1:0] C_ONE       = SIZE_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_REQ   = 2'd1,
        WR_BURST = 2'd2
    } state_t;

    state_t              r_state_q, w_state_d;
    logic [ADDR_W-1:0]   r_addr_q, w_addr_d;
    logic [SIZE_W-1:0]   r_len_q, w_len_d;
    logic [SIZE_W-1:0]   r_beat_cnt_q, w_beat_cnt_d;
    logic                r_first_q, w_first_d;
    logic [6:0]          r_outstanding_q, w_outstanding_d;
    logic [SIZE_W-1:0]   r_fifo_mem_q [RD_CMD_DEPTH];
    logic [C_PTR_W-1:0]  r_wr_ptr_q, w_wr_ptr_d;
    logic [C_PTR_W-1:0]  r_rd_ptr_q, w_rd_ptr_d;
    logic [C_PTR_W:0]    r_fifo_cnt_q, w_fifo_cnt_d;
    logic [SIZE_W-1:0]   r_ret_cnt_q, w_ret_cnt_d;
    logic                r_rsp_valid_q, w_rsp_valid_d;
    logic [DATA_W-1:0]   r_rsp_data_q, w_rsp_data_d;
    logic                r_rsp_last_q, w_rsp_last_d;
    logic                r_rd_underflow_q, w_rd_underflow_d;

    logic [SIZE_W-1:0]   w_cmd_len_eff;
    logic [7:0]          w_out_sum;
    logic                w_fifo_full;
    logic                w_rd_fits;
    logic                w_cmd_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_rd_issue;
    logic                w_wr_xfer;
    logic                w_ret;
    logic [SIZE_W-1:0]   w_fifo_head;
    logic [SIZE_W-1:0]   w_ret_cnt_inc;
    logic                w_ret_last;

    // Zero-length commands count as one beat; oversize lengths saturate.
    always_comb begin
        w_cmd_len_eff = cmd_len;
        if (cmd_len == '0) begin
            w_cmd_len_eff = C_ONE;
        end else if (cmd_len > C_MAX_BURST) begin
            w_cmd_len_eff = C_MAX_BURST;
        end
    end

    assign w_fifo_full   = (r_fifo_cnt_q == C_FIFO_FULL);
    assign w_out_sum     = 8'(r_outstanding_q) + 8'(w_cmd_len_eff);
    assign w_rd_fits     = !w_fifo_full && (w_out_sum <= C_MAX_OUT);
    assign cmd_ready     = (r_state_q == IDLE) && local_init_done && !reset_phy_clk &&
                           (cmd_write || w_rd_fits);
    assign w_cmd_accept  = cmd_valid && cmd_ready;
    assign w_push        = w_cmd_accept && !cmd_write;
    assign w_rd_issue    = (r_state_q == RD_REQ) && local_ready;
    assign w_wr_xfer     = (r_state_q == WR_BURST) && wr_valid && local_ready;

    // A return beat with nothing in flight is dropped and flagged instead.
    assign w_ret         = local_rdata_valid && (r_outstanding_q != '0);
    assign w_fifo_head   = r_fifo_mem_q[r_rd_ptr_q];
    assign w_ret_cnt_inc = r_ret_cnt_q + C_ONE;
    assign w_ret_last    = w_ret && (w_ret_cnt_inc == w_fifo_head);
    assign w_pop         = w_ret_last;

    always_comb begin
        w_state_d    = r_state_q;
        w_addr_d     = r_addr_q;
        w_len_d      = r_len_q;
        w_beat_cnt_d = r_beat_cnt_q;
        w_first_d    = r_first_q;
        case (r_state_q)
            IDLE: begin
                if (w_cmd_accept) begin
                    w_addr_d = cmd_addr;
                    w_len_d  = w_cmd_len_eff;
                    if (cmd_write) begin
                        w_beat_cnt_d = w_cmd_len_eff;
                        w_first_d    = 1'b1;
                        w_state_d    = WR_BURST;
                    end else begin
                        w_state_d    = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (local_ready) begin
                    w_state_d = IDLE;
                end
            end
            WR_BURST: begin
                if (w_wr_xfer) begin
                    w_first_d    = 1'b0;
                    w_beat_cnt_d = r_beat_cnt_q - C_ONE;
                    if (r_beat_cnt_q == C_ONE) begin
                        w_state_d = IDLE;
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        local_read_req   = (r_state_q == RD_REQ);
        local_write_req  = (r_state_q == WR_BURST) && wr_valid;
        local_burstbegin = (r_state_q == RD_REQ) || ((r_state_q == WR_BURST) && r_first_q);
        wr_ready         = (r_state_q == WR_BURST) && local_ready;
        local_wdata      = '0;
        local_be         = '0;
        if (r_state_q == WR_BURST) begin
            local_wdata = wr_data;
            local_be    = wr_be;
        end
    end

    // Issue (+len) and return (-1) can land in the same cycle; apply both.
    always_comb begin
        w_outstanding_d = r_outstanding_q;
        if (w_rd_issue) begin
            w_outstanding_d = w_outstanding_d + 7'(r_len_q);
        end
        if (w_ret) begin
            w_outstanding_d = w_outstanding_d - 7'd1;
        end
    end

    always_comb begin
        w_wr_ptr_d   = r_wr_ptr_q;
        w_rd_ptr_d   = r_rd_ptr_q;
        w_fifo_cnt_d = r_fifo_cnt_q;
        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr_q + C_PTR_ONE;
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + C_PTR_ONE;
        end
        case ({w_push, w_pop})
            2'b10:   w_fifo_cnt_d = r_fifo_cnt_q + 1'b1;
            2'b01:   w_fifo_cnt_d = r_fifo_cnt_q - 1'b1;
            default: w_fifo_cnt_d = r_fifo_cnt_q;
        endcase
    end

    always_comb begin
        w_ret_cnt_d      = r_ret_cnt_q;
        w_rsp_valid_d    = w_ret;
        w_rsp_last_d     = w_ret_last;
        w_rsp_data_d     = r_rsp_data_q;
        w_rd_underflow_d = r_rd_underflow_q;
        if (w_ret) begin
            w_rsp_data_d = local_rdata;
            w_ret_cnt_d  = w_ret_last ? '0 : w_ret_cnt_inc;
        end
        if (local_rdata_valid && (r_outstanding_q == '0)) begin
            w_rd_underflow_d = 1'b1;
        end
    end

    always_ff @(posedge phy_clk) begin
        if (reset_phy_clk) begin
            r_state_q        <= IDLE;
            r_addr_q         <= '0;
            r_len_q          <= '0;
            r_beat_cnt_q     <= '0;
            r_first_q        <= 1'b0;
            r_outstanding_q  <= '0;
            r_wr_ptr_q       <= '0;
            r_rd_ptr_q       <= '0;
            r_fifo_cnt_q     <= '0;
            r_ret_cnt_q      <= '0;
            r_rsp_valid_q    <= 1'b0;
            r_rsp_data_q     <= '0;
            r_rsp_last_q     <= 1'b0;
            r_rd_underflow_q <= 1'b0;
        end else begin
            r_state_q        <= w_state_d;
            r_addr_q         <= w_addr_d;
            r_len_q          <= w_len_d;
            r_beat_cnt_q     <= w_beat_cnt_d;
            r_first_q        <= w_first_d;
            r_outstanding_q  <= w_outstanding_d;
            r_wr_ptr_q       <= w_wr_ptr_d;
            r_rd_ptr_q       <= w_rd_ptr_d;
            r_fifo_cnt_q     <= w_fifo_cnt_d;
            r_ret_cnt_q      <= w_ret_cnt_d;
            r_rsp_valid_q    <= w_rsp_valid_d;
            r_rsp_data_q     <= w_rsp_data_d;
            r_rsp_last_q     <= w_rsp_last_d;
            r_rd_underflow_q <= w_rd_underflow_d;
        end
    end

    // Storage only; validity is tracked by the reset pointers and count.
    always_ff @(posedge phy_clk) begin
        if (w_push) begin
            r_fifo_mem_q[r_wr_ptr_q] <= w_cmd_len_eff;
        end
    end

    assign local_address     = r_addr_q;
    assign local_size        = r_len_q;
    assign outstanding_beats = r_outstanding_q;
    assign rsp_valid         = r_rsp_valid_q;
    assign rsp_data          = r_rsp_data_q;
    assign rsp_last          = r_rsp_last_q;
    assign rd_underflow      = r_rd_underflow_q;

endmodule
`default_nettype wire
